multdiv_sched: RTL and testbench

- Sequencer and HI/LO owner for the EXE-stage iterative multiply/divide unit.
- Accepts mult/multu/div/divu issues and latches operands, then pulses start to the unit and waits for done. On done it writes HI/LO.
- Generates the pipeline stall for any HI/LO-touching instruction (mfhi/mflo/mthi/mtlo, or a new md op) while an operation is in flight.
- Sits between ID/EXE control and the multdiv datapath. It replaces the ad-hoc keep/busy glue logic.

---
 rtl/multdiv_sched.sv | 187 ++++++++++++++++++
 tb/tb_multdiv_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sched.sv
// ---------------------------------------------------------------------------
// multdiv_sched
//
// Sequencer and HI/LO owner for the EXE-stage iterative multiply/divide unit.
// It accepts mult/multu/div/divu issues, latches the operands, pulses
// md_start to the unit and waits for md_done.  The returned result is
// written to the architectural HI/LO registers one cycle later.  While an
// operation is in flight, any HI/LO-touching instruction stalls the pipe.
//
// Optional feature (compile-time macro MULTDIV_DIVZERO_BYPASS_EN):
//   when defined, a div/divu with a zero divisor bypasses the unit and goes
//   straight to WRITE with HI = dividend, LO = all ones.  When undefined,
//   divide-by-zero is sent to the unit like any other operation.
//
// Parameters:
//   TIMEOUT : maximum cycles in WAIT before the operation is aborted (>= 2)
//   CW      : width of the timeout counter, 2**CW must exceed TIMEOUT
// ---------------------------------------------------------------------------
module multdiv_sched #(
    parameter int TIMEOUT = 40,
    parameter int CW      = 6
) (
    input  logic        clk,
    input  logic        clrn,

    // issue from EXE
    input  logic        issue_valid,
    input  logic [1:0]  issue_op,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,

    // HI/LO access from EXE
    input  logic        mfhi_req,
    input  logic        mflo_req,
    input  logic        mthi_req,
    input  logic        mtlo_req,
    input  logic [31:0] mt_data,

    // multdiv unit handshake
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_done,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,

    // architectural state and status
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        hilo_we,
    output logic        busy,
    output logic        stall,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    md_op_q;
    logic [31:0]   md_a_q;
    logic [31:0]   md_b_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   res_hi_q;
    logic [31:0]   res_lo_q;
    logic          md_start_q;
    logic          hilo_we_q;
    logic          timeout_err_q;

    logic          div_by_zero;
    logic          hilo_access;

    // Detect an issue that can be answered without the unit.
`ifdef MULTDIV_DIVZERO_BYPASS_EN
    assign div_by_zero = issue_op[1] & (issue_b == 32'd0);
`else
    assign div_by_zero = 1'b0;
`endif

    // Any instruction that reads or writes HI/LO, or starts a new md op.
    assign hilo_access = issue_valid | mfhi_req | mflo_req | mthi_req | mtlo_req;

    // Sequencer FSM, HI/LO registers and all registered outputs.
    // NOTE: every register in this block uses non-blocking assignment so that
    // all branches see the pre-edge values of state_q/cnt_q, regardless of
    // statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            md_op_q       <= 2'b00;
            md_a_q        <= '0;
            md_b_q        <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            res_hi_q      <= '0;
            res_lo_q      <= '0;
            md_start_q    <= 1'b0;
            hilo_we_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // mt writes land now; a simultaneous issue's result
                    // overwrites them later in WRITE.
                    if (mthi_req) hi_q <= mt_data;
                    if (mtlo_req) lo_q <= mt_data;
                    if (issue_valid) begin
                        md_op_q <= issue_op;
                        md_a_q  <= issue_a;
                        md_b_q  <= issue_b;
                        if (div_by_zero) begin
                            res_hi_q  <= issue_a;
                            res_lo_q  <= 32'hFFFF_FFFF;
                            hilo_we_q <= 1'b1;
                            state_q   <= S_WRITE;
                        end else begin
                            md_start_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    // Start is high for exactly this one cycle.
                    md_start_q <= 1'b0;
                    cnt_q      <= '0;
                    if (md_done) begin
                        res_hi_q  <= md_hi;
                        res_lo_q  <= md_lo;
                        hilo_we_q <= 1'b1;
                        state_q   <= S_WRITE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A done arriving in the last allowed cycle still wins.
                    if (md_done) begin
                        res_hi_q  <= md_hi;
                        res_lo_q  <= md_lo;
                        hilo_we_q <= 1'b1;
                        state_q   <= S_WRITE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end

                S_WRITE: begin
                    hilo_we_q <= 1'b0;
                    hi_q      <= res_hi_q;
                    lo_q      <= res_lo_q;
                    state_q   <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output mapping; stall is the only combinational output besides busy.
    assign md_start    = md_start_q;
    assign md_op       = md_op_q;
    assign md_a        = md_a_q;
    assign md_b        = md_b_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign hilo_we     = hilo_we_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);
    assign stall       = hilo_access & busy;

endmodule

// File: tb/tb_multdiv_sched.sv
// ---------------------------------------------------------------------------
// tb_multdiv_sched
//
// Directed bench for multdiv_sched.  The bench plays the multdiv unit by
// driving md_done/md_hi/md_lo at hand-chosen cycles.  Inputs change 1 ns
// after the rising edge and outputs are sampled in that same window.
// Build with +define+MULTDIV_DIVZERO_BYPASS_EN to exercise the bypass.
// ---------------------------------------------------------------------------
module tb_multdiv_sched;

    logic        clk;
    logic        clrn;
    logic        issue_valid;
    logic [1:0]  issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        mfhi_req;
    logic        mflo_req;
    logic        mthi_req;
    logic        mtlo_req;
    logic [31:0] mt_data;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_done;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hilo_we;
    logic        busy;
    logic        stall;
    logic        timeout_err;

    int n_checks;
    int n_errors;

    multdiv_sched #(.TIMEOUT(40), .CW(6)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .mfhi_req    (mfhi_req),
        .mflo_req    (mflo_req),
        .mthi_req    (mthi_req),
        .mtlo_req    (mtlo_req),
        .mt_data     (mt_data),
        .md_start    (md_start),
        .md_op       (md_op),
        .md_a        (md_a),
        .md_b        (md_b),
        .md_done     (md_done),
        .md_hi       (md_hi),
        .md_lo       (md_lo),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .hilo_we     (hilo_we),
        .busy        (busy),
        .stall       (stall),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
    endtask

    initial begin
        int n_busy;
        int n_start;
        int n_we;
        int stall_bad;

        n_checks    = 0;
        n_errors    = 0;
        clrn        = 1'b0;
        issue_valid = 1'b0;
        issue_op    = 2'b00;
        issue_a     = '0;
        issue_b     = '0;
        mfhi_req    = 1'b0;
        mflo_req    = 1'b0;
        mthi_req    = 1'b0;
        mtlo_req    = 1'b0;
        mt_data     = '0;
        md_done     = 1'b0;
        md_hi       = '0;
        md_lo       = '0;

        // ---------------- reset state ----------------
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_start", {31'd0, md_start}, 32'd0);
        check("rst_op", {30'd0, md_op}, 32'd0);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        step();
        clrn = 1'b1;
        step();

        // ---------------- mthi / mtlo in IDLE ----------------
        mthi_req = 1'b1;
        mt_data  = 32'hDEAD_BEEF;
        #1 check("mthi_idle_stall", {31'd0, stall}, 32'd0);
        step();
        mthi_req = 1'b0;
        check("mthi_idle_hi", hi_out, 32'hDEAD_BEEF);
        mtlo_req = 1'b1;
        mt_data  = 32'h1234_5678;
        step();
        mtlo_req = 1'b0;
        check("mtlo_idle_lo", lo_out, 32'h1234_5678);
        check("mtlo_idle_hi_kept", hi_out, 32'hDEAD_BEEF);

        // ---------------- multu 0x10000 * 0x10000, done 33 cycles after start ----------------
        issue(2'b01, 32'h0001_0000, 32'h0001_0000);
        #1 check("multu_accept_stall", {31'd0, stall}, 32'd0);
        step();                                         // cycle 1: ISSUE
        issue_valid = 1'b0;
        check("multu_start", {31'd0, md_start}, 32'd1);
        check("multu_busy_issue", {31'd0, busy}, 32'd1);
        check("multu_op", {30'd0, md_op}, 32'd1);
        check("multu_a", md_a, 32'h0001_0000);
        check("multu_b", md_b, 32'h0001_0000);
        n_start = 0;
        n_busy  = 0;
        for (int c = 2; c <= 33; c++) begin
            step();
            if (md_start) n_start++;
            if (busy) n_busy++;
        end
        check("multu_start_once", n_start, 32'd0);
        check("multu_busy_wait", n_busy, 32'd32);
        step();                                         // cycle 34: done
        md_done = 1'b1;
        md_hi   = 32'h1;
        md_lo   = 32'h0;
        check("multu_we_before", {31'd0, hilo_we}, 32'd0);
        step();                                         // cycle 35: WRITE
        md_done = 1'b0;
        md_hi   = 32'hBAD0_BAD0;
        md_lo   = 32'hBAD0_BAD0;
        check("multu_we", {31'd0, hilo_we}, 32'd1);
        check("multu_busy_write", {31'd0, busy}, 32'd1);
        check("multu_hi_old", hi_out, 32'hDEAD_BEEF);
        step();                                         // cycle 36: IDLE
        check("multu_busy_done", {31'd0, busy}, 32'd0);
        check("multu_we_off", {31'd0, hilo_we}, 32'd0);
        check("multu_hi", hi_out, 32'h1);
        check("multu_lo", lo_out, 32'h0);

        // ---------------- mult with done in ISSUE, plus mtlo on the issue cycle ----------------
        issue(2'b00, 32'hFFFF_FFFE, 32'd3);             // -2 * 3 = -6
        mtlo_req = 1'b1;
        mt_data  = 32'h0000_0055;
        step();                                         // ISSUE
        issue_valid = 1'b0;
        mtlo_req    = 1'b0;
        check("mult_mt_same_cycle", lo_out, 32'h0000_0055);
        check("mult_start", {31'd0, md_start}, 32'd1);
        md_done = 1'b1;
        md_hi   = 32'hFFFF_FFFF;
        md_lo   = 32'hFFFF_FFFA;
        step();                                         // WRITE
        md_done = 1'b0;
        check("mult_issue_done_we", {31'd0, hilo_we}, 32'd1);
        check("mult_start_off", {31'd0, md_start}, 32'd0);
        step();
        check("mult_hi", hi_out, 32'hFFFF_FFFF);
        check("mult_lo", lo_out, 32'hFFFF_FFFA);

        // ---------------- hazard: div 100/7 with mflo + mthi held ----------------
        issue(2'b10, 32'd100, 32'd7);
        step();                                         // cycle 1: ISSUE
        issue_valid = 1'b0;
        mflo_req    = 1'b1;
        mthi_req    = 1'b1;
        mt_data     = 32'hCAFE_F00D;
        stall_bad   = 0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            if (!stall) stall_bad++;
            if (c == 5) begin
                md_done = 1'b1;
                md_hi   = 32'd2;                        // remainder
                md_lo   = 32'd14;                       // quotient
            end
            step();
        end
        md_done = 1'b0;                                 // cycle 6: WRITE
        #1 check("hazard_stall_wait", stall_bad, 32'd0);
        check("hazard_stall_write", {31'd0, stall}, 32'd1);
        check("hazard_mthi_held", hi_out, 32'hFFFF_FFFF);
        step();                                         // cycle 7: first IDLE
        #1 check("hazard_stall_idle", {31'd0, stall}, 32'd0);
        check("hazard_lo", lo_out, 32'd14);
        check("hazard_hi", hi_out, 32'd2);
        step();                                         // mthi took effect
        mflo_req = 1'b0;
        mthi_req = 1'b0;
        check("hazard_mthi_after", hi_out, 32'hCAFE_F00D);
        check("hazard_lo_kept", lo_out, 32'd14);

        // ---------------- timeout: divu with no done ----------------
        issue(2'b11, 32'd5, 32'd3);
        step();                                         // ISSUE
        issue_valid = 1'b0;
        step();                                         // first WAIT cycle
        n_busy = 0;
        n_we   = 0;
        for (int c = 0; c < 100 && busy; c++) begin
            n_busy++;
            if (hilo_we) n_we++;
            if (n_busy == 40) check("tmo_err_late", {31'd0, timeout_err}, 32'd0);
            step();
        end
        check("tmo_wait_cycles", n_busy, 32'd40);
        check("tmo_no_we", n_we, 32'd0);
        check("tmo_err", {31'd0, timeout_err}, 32'd1);
        check("tmo_hi_kept", hi_out, 32'hCAFE_F00D);
        check("tmo_lo_kept", lo_out, 32'd14);

        // ---------------- divide by zero: div 7/0 ----------------
        issue(2'b10, 32'd7, 32'd0);
        step();
        issue_valid = 1'b0;
`ifdef MULTDIV_DIVZERO_BYPASS_EN
        check("dz_no_start", {31'd0, md_start}, 32'd0);
        check("dz_we", {31'd0, hilo_we}, 32'd1);
        step();
        check("dz_busy", {31'd0, busy}, 32'd0);
`else
        check("dz_start", {31'd0, md_start}, 32'd1);
        step();                                         // WAIT
        md_done = 1'b1;
        md_hi   = 32'd7;
        md_lo   = 32'hFFFF_FFFF;
        step();                                         // WRITE
        md_done = 1'b0;
        check("dz_we", {31'd0, hilo_we}, 32'd1);
        step();
`endif
        check("dz_hi", hi_out, 32'd7);
        check("dz_lo", lo_out, 32'hFFFF_FFFF);
        check("dz_terr_sticky", {31'd0, timeout_err}, 32'd1);

        // ---------------- async reset mid-WAIT ----------------
        issue(2'b01, 32'd9, 32'd9);
        step();
        issue_valid = 1'b0;
        step();
        step();                                         // in WAIT
        mflo_req = 1'b1;
        #2 clrn = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_start", {31'd0, md_start}, 32'd0);
        check("arst_hi", hi_out, 32'd0);
        check("arst_lo", lo_out, 32'd0);
        check("arst_terr", {31'd0, timeout_err}, 32'd0);
        mflo_req = 1'b0;
        step();
        clrn = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
